// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : counter_pkg
//  Purpose  : Shared opcodes, FSM states, strobe bundle and helpers for the
//             counter command sequencer and its command FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
package counter_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_INC  = 3'd2;
    localparam logic [2:0] OP_DEC  = 3'd3;
    localparam logic [2:0] OP_SHL  = 3'd4;
    localparam logic [2:0] OP_SHR  = 3'd5;
    localparam logic [2:0] OP_CLR  = 3'd6;
    localparam logic [2:0] OP_WAIT = 3'd7;

    localparam int OP_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    // Counter control strobes; at most one field is ever set.
    typedef struct packed {
        logic clr;
        logic l;
        logic inc;
        logic dec;
        logic shl;
        logic shr;
    } strobe_t;

    // Packed FIFO entry width: {op, arg, rep}.
    function automatic int cmd_width(input int n, input int rw);
        return OP_W + n + rw;
    endfunction

    // Strobe pattern driven while an opcode executes.
    function automatic strobe_t op_strobes(input logic [2:0] op);
        strobe_t s;
        s = '0;
        case (op)
            OP_LOAD: s.l   = 1'b1;
            OP_INC:  s.inc = 1'b1;
            OP_DEC:  s.dec = 1'b1;
            OP_SHL:  s.shl = 1'b1;
            OP_SHR:  s.shr = 1'b1;
            OP_CLR:  s.clr = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

    // Opcodes that honour the repeat field; the rest always last one cycle.
    function automatic logic op_repeats(input logic [2:0] op);
        return (op == OP_INC) || (op == OP_DEC) || (op == OP_SHL) ||
               (op == OP_SHR) || (op == OP_WAIT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Register-based synchronous FIFO with occupancy count.
//             Push when full and pop when empty are ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         C,
    input  logic                         R,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge C) begin
        if (!R) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage array; contents need no reset because the pointers are flushed.
    always_ff @(posedge C) begin
        if (R && do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule
`default_nettype wire

// File: rtl/counter_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : counter_cmd_sequencer
//  Purpose  : Buffers counter opcodes in a FIFO and replays each one as
//             registered, mutually exclusive counter strobes plus data word D.
//  Revision : 1.0 - initial release
// ============================================================================
module counter_cmd_sequencer
    import counter_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 4,
    parameter int RW    = 4
) (
    input  logic          C,
    input  logic          R,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [N-1:0]  cmd_arg,
    input  logic [RW-1:0] cmd_rep,
    input  logic          hold,
    output logic [N-1:0]  D,
    output logic          CLR,
    output logic          L,
    output logic          INC,
    output logic          DEC,
    output logic          SHL,
    output logic          SHR,
    output logic          busy
);

    localparam int CW = cmd_width(N, RW);

    logic [CW-1:0]         fifo_din;
    logic [CW-1:0]         fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  fifo_push;
    logic                  do_pop;

    logic [2:0]            head_op;
    logic [N-1:0]          head_arg;
    logic [RW-1:0]         head_rep;

    state_t                state;
    logic [2:0]            op_q;
    logic [RW-1:0]         rem_q;
    strobe_t               strb_q;

    assign fifo_din  = {cmd_op, cmd_arg, cmd_rep};
    assign fifo_push = cmd_valid;

    assign head_op  = fifo_dout[CW-1 -: OP_W];
    assign head_arg = fifo_dout[RW +: N];
    assign head_rep = fifo_dout[RW-1:0];

    // A new command is taken when idle or on the final cycle of the current
    // one, unless execution is frozen.
    assign do_pop = ~hold & ~fifo_empty &
                    ((state == ST_IDLE) || (rem_q == '0));

    sync_fifo #(
        .WIDTH (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .C     (C),
        .R     (R),
        .push  (fifo_push),
        .pop   (do_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sequencer FSM with registered strobes and data; the strobes for the
    // next cycle are decided at each edge so outputs never see inputs
    // combinationally.
    always_ff @(posedge C) begin
        if (!R) begin
            state  <= ST_IDLE;
            op_q   <= OP_NOP;
            rem_q  <= '0;
            strb_q <= '0;
            D      <= '0;
        end else if (hold) begin
            strb_q <= '0;
        end else if (do_pop) begin
            state  <= ST_EXEC;
            op_q   <= head_op;
            rem_q  <= op_repeats(head_op) ? head_rep : '0;
            strb_q <= op_strobes(head_op);
            D      <= head_arg;
        end else if (state == ST_EXEC) begin
            if (rem_q == '0) begin
                state  <= ST_IDLE;
                strb_q <= '0;
            end else begin
                rem_q  <= rem_q - RW'(1);
                strb_q <= op_strobes(op_q);
            end
        end
    end

    assign CLR = strb_q.clr;
    assign L   = strb_q.l;
    assign INC = strb_q.inc;
    assign DEC = strb_q.dec;
    assign SHL = strb_q.shl;
    assign SHR = strb_q.shr;

    assign cmd_ready = ~fifo_full;
    assign busy      = (state == ST_EXEC) | (fifo_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_counter_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_cmd_sequencer
//  Purpose  : Scoreboard bench: a command-level reference model predicts each
//             cycle's outputs into a queue that a monitor drains and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_counter_cmd_sequencer;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int RW    = 4;

    logic          C = 1'b0;
    logic          R;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [N-1:0]  cmd_arg;
    logic [RW-1:0] cmd_rep;
    logic          hold;
    logic [N-1:0]  D;
    logic          CLR, L, INC, DEC, SHL, SHR;
    logic          busy;

    int checks = 0;
    int errors = 0;

    counter_cmd_sequencer #(.N(N), .DEPTH(DEPTH), .RW(RW)) dut (
        .C(C), .R(R), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_rep(cmd_rep), .hold(hold),
        .D(D), .CLR(CLR), .L(L), .INC(INC), .DEC(DEC), .SHL(SHL), .SHR(SHR),
        .busy(busy)
    );

    always #5 C = ~C;

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0]    op;
        logic [N-1:0]  arg;
        logic [RW-1:0] rep;
    } cmd_t;

    typedef struct {
        logic [5:0]   strb;   // {CLR,L,INC,DEC,SHL,SHR}
        logic [N-1:0] d;
        logic         busy;
        logic         ready;
    } exp_t;

    cmd_t   mq[$];
    exp_t   eq[$];
    bit     m_active = 0;
    int     m_left   = 0;
    logic [2:0]   m_op = 3'd0;
    logic [N-1:0] m_d  = '0;

    // Number of execution cycles an opcode occupies.
    function automatic int run_len(input logic [2:0] op, input logic [RW-1:0] rep);
        if (op >= 3'd2 && op <= 3'd5) return int'(rep) + 1;
        if (op == 3'd7)               return int'(rep) + 1;
        return 1;
    endfunction

    function automatic logic [5:0] strb_of(input logic [2:0] op);
        case (op)
            3'd1: return 6'b010000;
            3'd2: return 6'b001000;
            3'd3: return 6'b000100;
            3'd4: return 6'b000010;
            3'd5: return 6'b000001;
            3'd6: return 6'b100000;
            default: return 6'b000000;
        endcase
    endfunction

    always @(posedge C) begin : model
        exp_t e;
        cmd_t c;
        cmd_t h;
        bit   acc;
        e.strb = 6'b0;
        if (!R) begin
            mq.delete();
            m_active = 0;
            m_left   = 0;
            m_d      = '0;
        end else begin
            acc   = cmd_valid && (mq.size() < DEPTH);
            c.op  = cmd_op;
            c.arg = cmd_arg;
            c.rep = cmd_rep;
            if (hold) begin
                e.strb = 6'b0;
            end else if (m_active && m_left > 0) begin
                m_left = m_left - 1;
                e.strb = strb_of(m_op);
            end else if (mq.size() > 0) begin
                h        = mq.pop_front();
                m_active = 1;
                m_op     = h.op;
                m_left   = run_len(h.op, h.rep) - 1;
                m_d      = h.arg;
                e.strb   = strb_of(h.op);
            end else begin
                m_active = 0;
            end
            if (acc) mq.push_back(c);
        end
        e.d     = m_d;
        e.busy  = m_active || (mq.size() > 0);
        e.ready = (mq.size() < DEPTH);
        eq.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge C) begin : monitor
        exp_t e;
        logic [5:0] act;
        if (eq.size() > 0) begin
            e   = eq.pop_front();
            act = {CLR, L, INC, DEC, SHL, SHR};
            checks++;
            if (act !== e.strb) begin
                errors++;
                $display("FAIL strobes @%0t: got %b expected %b", $time, act, e.strb);
            end
            checks++;
            if (D !== e.d) begin
                errors++;
                $display("FAIL D @%0t: got %h expected %h", $time, D, e.d);
            end
            checks++;
            if (busy !== e.busy) begin
                errors++;
                $display("FAIL busy @%0t: got %b expected %b", $time, busy, e.busy);
            end
            checks++;
            if (cmd_ready !== e.ready) begin
                errors++;
                $display("FAIL cmd_ready @%0t: got %b expected %b", $time, cmd_ready, e.ready);
            end
            checks++;
            if ($countones(act) > 1) begin
                errors++;
                $display("FAIL onehot @%0t: got %b expected at most one strobe", $time, act);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [2:0] op, input logic [N-1:0] arg,
                         input logic [RW-1:0] rep, input logic h, input logic r);
        cmd_valid = v;
        cmd_op    = op;
        cmd_arg   = arg;
        cmd_rep   = rep;
        hold      = h;
        R         = r;
        @(negedge C);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
    endtask

    // Offer one command, waiting (bounded) for space first.
    task automatic push(input logic [2:0] op, input logic [N-1:0] arg,
                        input logic [RW-1:0] rep, input logic h);
        int t;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 50) begin
            drive(1'b0, 3'd0, '0, '0, h, 1'b1);
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: cmd_ready got %b expected 1 within 50 cycles", cmd_ready);
        end else begin
            drive(1'b1, op, arg, rep, h, 1'b1);
        end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = '0; cmd_rep = '0;
        hold = 1'b0; R = 1'b0;
        @(negedge C);
        repeat (2) drive(1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
        idle(2);

        // Single LOAD: rep ignored.
        push(3'd1, 4'hA, 4'd7, 1'b0);
        idle(5);

        // INC x3, DEC x1, SHL x2 back-to-back.
        push(3'd2, 4'h3, 4'd2, 1'b0);
        push(3'd3, 4'h5, 4'd0, 1'b0);
        push(3'd4, 4'h1, 4'd1, 1'b0);
        idle(10);

        // hold for two cycles in the middle of INC rep=3.
        push(3'd2, 4'h7, 4'd3, 1'b0);
        push(3'd3, 4'h2, 4'd0, 1'b0);
        drive(1'b0, 3'd0, '0, '0, 1'b1, 1'b1);
        drive(1'b0, 3'd0, '0, '0, 1'b1, 1'b1);
        idle(10);

        // Fill under hold, attempt a fifth push, then release.
        for (int i = 0; i < 4; i++) push(3'd7, 4'(i), 4'd3, 1'b1);
        drive(1'b1, 3'd2, 4'hF, 4'd0, 1'b1, 1'b1);
        idle(25);

        // Reset in the middle of INC rep=5 with three queued.
        push(3'd2, 4'h9, 4'd5, 1'b0);
        push(3'd3, 4'h1, 4'd2, 1'b0);
        push(3'd6, 4'h2, 4'd0, 1'b0);
        push(3'd1, 4'h3, 4'd0, 1'b0);
        drive(1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
        idle(10);

        // Back-to-back NOP/CLR.
        for (int i = 0; i < 6; i++) push((i % 2 == 0) ? 3'd0 : 3'd6, 4'(i + 1), 4'd5, 1'b0);
        idle(8);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 6,
                  3'($urandom_range(0, 7)),
                  4'($urandom),
                  ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2)),
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 299) != 0);
        end
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
